// File: rtl/rx_bit_unstuff_deser_pkg.sv
// Shared types and constants for the USB receive bit path.
// Covers the unstuff/deserialiser state encoding, the SYNC pattern and the byte width.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_EOP   = 2'd2,
    ST_ABORT = 2'd3
  } rx_state_e;

  // SYNC as decoded, LSB first: seven zeros then the terminating one
  localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;
  localparam int         BYTE_W       = 8;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

endpackage

// File: rtl/rx_bit_unstuff_deser_if.sv
// Bit-level link between the NRZI decoder and the unstuff/deserialiser,
// plus the UTMI-style receive outputs.
interface rx_bit_unstuff_deser_if;
  logic       sample;
  logic       nrzi_bit;
  logic       stuffed;
  logic       stuff_err;
  logic       se0;
  logic       shift_en;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_error;

  // decoder side: supplies bits, consumes shift_en and the receive outputs
  modport master (
    output sample, nrzi_bit, stuffed, stuff_err, se0,
    input  shift_en, rx_active, rx_valid, rx_data, rx_error
  );

  // unstuff/deserialiser side
  modport slave (
    input  sample, nrzi_bit, stuffed, stuff_err, se0,
    output shift_en, rx_active, rx_valid, rx_data, rx_error
  );
endinterface

// File: rtl/rx_bit_unstuff_deser_shifter.sv
// LSB-first byte assembler: holds the partial byte and bit count, and flags
// the shift that completes a byte (byte_o is valid together with done_o).
module rx_byte_shifter
  import usb_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic              clr_i,
  input  logic              bit_i,
  output logic [BYTE_W-1:0] byte_o,
  output logic [2:0]        bit_cnt_o,
  output logic              done_o
);

  // only the seven most recent bits are kept; the eighth arrives with the completing shift
  logic [BYTE_W-2:0] sr_q;
  logic [2:0]        bit_cnt_q;

  // shift register and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
    end else if (clr_i) begin
      sr_q      <= '0;
      bit_cnt_q <= 3'd0;
    end else if (shift_i) begin
      sr_q      <= {bit_i, sr_q[BYTE_W-2:1]};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

  assign byte_o    = {bit_i, sr_q};
  assign bit_cnt_o = bit_cnt_q;
  assign done_o    = shift_i && (bit_cnt_q == 3'd7);

endmodule

// File: rtl/rx_bit_unstuff_deser.sv
// Receive stage after the NRZI decoder: SYNC hunt, stuffed-bit removal,
// LSB-first byte assembly, EOP detection and stuff-error reporting.
module rx_bit_unstuff_deser
  import usb_rx_pkg::*;
#(
  parameter int SYNC_ZEROS = 5,
  parameter int EOP_SE0    = 2
) (
  input logic                   clk,
  input logic                   rst,
  rx_bit_unstuff_deser_if.slave bus
);

  localparam int               SE0_W    = $clog2(EOP_SE0 + 1);
  localparam logic [2:0]       SYNC_MIN = 3'(SYNC_ZEROS);
  localparam logic [SE0_W-1:0] SE0_LAST = SE0_W'(EOP_SE0 - 1);

  rx_state_e         state_q;
  logic [2:0]        zero_cnt_q;
  logic [SE0_W-1:0]  se0_cnt_q;
  logic              shift_en_q;
  logic              rx_active_q;
  logic              rx_valid_q;
  logic              rx_error_q;
  logic [BYTE_W-1:0] rx_data_q;

  logic              lock_s;
  logic              shift_s;
  logic              clr_s;
  logic [BYTE_W-1:0] byte_s;
  logic [2:0]        bit_cnt_s;
  logic              byte_done_s;

  rx_byte_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .shift_i  (shift_s),
    .clr_i    (clr_s),
    .bit_i    (bus.nrzi_bit),
    .byte_o   (byte_s),
    .bit_cnt_o(bit_cnt_s),
    .done_o   (byte_done_s)
  );

  assign lock_s = !bus.se0 && (bus.nrzi_bit == SYNC_PATTERN[BYTE_W-1]) && (zero_cnt_q >= SYNC_MIN);

  // shifter control: shift real data bits, clear on lock and on leaving DATA
  always_comb begin
    shift_s = 1'b0;
    clr_s   = 1'b0;
    if (bus.sample) begin
      case (state_q)
        ST_HUNT: clr_s = lock_s;
        ST_DATA: begin
          if (bus.se0) begin
            clr_s = (se0_cnt_q == SE0_LAST);
          end else if (bus.stuff_err) begin
            clr_s = 1'b1;
          end else begin
            shift_s = !bus.stuffed;
          end
        end
        default: clr_s = 1'b0;
      endcase
    end else begin
      clr_s = 1'b0;
    end
  end

  // packet FSM, SYNC/SE0 counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      zero_cnt_q  <= 3'd0;
      se0_cnt_q   <= '0;
      shift_en_q  <= 1'b0;
      rx_active_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      rx_data_q   <= 8'h00;
    end else begin
      rx_valid_q <= 1'b0;
      rx_error_q <= 1'b0;
      if (bus.sample) begin
        case (state_q)
          ST_HUNT: begin
            if (bus.se0) begin
              zero_cnt_q <= 3'd0;
            end else if (!bus.nrzi_bit) begin
              zero_cnt_q <= sat_inc3(zero_cnt_q);
            end else if (lock_s) begin
              state_q     <= ST_DATA;
              shift_en_q  <= 1'b1;
              rx_active_q <= 1'b1;
              zero_cnt_q  <= 3'd0;
              se0_cnt_q   <= '0;
            end else begin
              zero_cnt_q <= 3'd0;
            end
          end
          ST_DATA: begin
            if (bus.se0) begin
              if (se0_cnt_q == SE0_LAST) begin
                state_q    <= ST_EOP;
                shift_en_q <= 1'b0;
                se0_cnt_q  <= '0;
                rx_error_q <= (bit_cnt_s != 3'd0);
              end else begin
                se0_cnt_q <= se0_cnt_q + SE0_W'(1);
              end
            end else if (bus.stuff_err) begin
              state_q    <= ST_ABORT;
              shift_en_q <= 1'b0;
              se0_cnt_q  <= '0;
              rx_error_q <= 1'b1;
            end else begin
              se0_cnt_q <= '0;
              if (byte_done_s) begin
                rx_data_q  <= byte_s;
                rx_valid_q <= 1'b1;
              end
            end
          end
          ST_EOP: begin
            if (!bus.se0) begin
              state_q     <= ST_HUNT;
              rx_active_q <= 1'b0;
            end
          end
          ST_ABORT: begin
            if (bus.se0) begin
              state_q <= ST_EOP;
            end
          end
          default: begin
            state_q     <= ST_HUNT;
            shift_en_q  <= 1'b0;
            rx_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.shift_en  = shift_en_q;
  assign bus.rx_active = rx_active_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_error  = rx_error_q;
  assign bus.rx_data   = rx_data_q;

endmodule

// File: tb/tb_rx_bit_unstuff_deser.sv
// Bench for rx_bit_unstuff_deser: packets are described as logical bit lists with
// stuffing/glitch/error annotations; expected bytes and errors go to a scoreboard.
module tb_rx_bit_unstuff_deser;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rx_bit_unstuff_deser_if bus_if();

  rx_bit_unstuff_deser #(.SYNC_ZEROS(5), .EOP_SE0(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  total = 0;
  int  bad   = 0;

  // packet description: logical bits, stuffed bit after bit i, single-SE0 glitch before bit i
  bit lb[$];
  bit st_after[$];
  bit gl_before[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one bit time: sample high for one edge, then ignored junk with random idle gaps
  task automatic drive_bit(input bit b, input bit st, input bit se, input bit serr);
    int g;
    @(negedge clk);
    bus_if.sample    = 1'b1;
    bus_if.nrzi_bit  = b;
    bus_if.stuffed   = st;
    bus_if.se0       = se;
    bus_if.stuff_err = serr;
    @(posedge clk);
    #1;
    bus_if.sample    = 1'b0;
    bus_if.nrzi_bit  = 1'($urandom);
    bus_if.stuffed   = 1'($urandom);
    bus_if.se0       = 1'($urandom);
    bus_if.stuff_err = 1'($urandom);
    g = $urandom_range(0, 2);
    for (int k = 0; k < g; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_ones(input int n);
    for (int k = 0; k < n; k++) drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_pkt();
    lb.delete();
    st_after.delete();
    gl_before.delete();
  endtask

  task automatic add_bit(input bit b, input bit st, input bit gl);
    lb.push_back(b);
    st_after.push_back(st);
    gl_before.push_back(gl);
  endtask

  task automatic load_byte(input logic [7:0] v);
    for (int j = 0; j < 8; j++) add_bit(v[j], 1'b0, 1'b0);
  endtask

  task automatic do_sync(input int nz);
    idle_ones(1 + $urandom_range(0, 3));
    chk("hunt_shift_en", 32'(bus_if.shift_en), 32'd0);
    for (int k = 0; k < nz; k++) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_lock_shift_en", 32'(bus_if.shift_en), 32'd0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    chk("lock_shift_en", 32'(bus_if.shift_en), 32'd1);
    chk("lock_rx_active", 32'(bus_if.rx_active), 32'd1);
  endtask

  // expected events from the packet description, then drive body and EOP
  task automatic do_body(input int err_pos);
    int   n;
    ev_t  e;
    n = (err_pos >= 0) ? err_pos : lb.size();
    for (int k = 0; k < n / 8; k++) begin
      e.is_err = 1'b0;
      for (int j = 0; j < 8; j++) e.data[j] = lb[8*k + j];
      exp_q.push_back(e);
    end
    if (err_pos >= 0 || (n % 8) != 0) begin
      e.is_err = 1'b1;
      e.data   = 8'h00;
      exp_q.push_back(e);
    end
    for (int i = 0; i < lb.size(); i++) begin
      if (i == err_pos) begin
        drive_bit(1'($urandom), 1'b0, 1'b0, 1'b1);
        break;
      end
      if (gl_before[i]) drive_bit(1'($urandom), 1'b0, 1'b1, 1'b0);
      drive_bit(lb[i], 1'b0, 1'b0, 1'b0);
      if (st_after[i]) drive_bit(1'b0, 1'b1, 1'b0, 1'b0);
    end
    if (err_pos >= 0) begin
      chk("abort_shift_en", 32'(bus_if.shift_en), 32'd0);
      chk("abort_rx_active", 32'(bus_if.rx_active), 32'd1);
      repeat ($urandom_range(0, 4)) drive_bit(1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    end
    drive_bit(1'b0, 1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b0, 1'b1, 1'b0);
    chk("eop_shift_en", 32'(bus_if.shift_en), 32'd0);
    chk("eop_rx_active", 32'(bus_if.rx_active), 32'd1);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    chk("j_rx_active", 32'(bus_if.rx_active), 32'd0);
    chk("j_shift_en", 32'(bus_if.shift_en), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_shift_en"}, 32'(bus_if.shift_en), 32'd0);
    chk({tag, "_rx_active"}, 32'(bus_if.rx_active), 32'd0);
    chk({tag, "_rx_valid"}, 32'(bus_if.rx_valid), 32'd0);
    chk({tag, "_rx_error"}, 32'(bus_if.rx_error), 32'd0);
    chk({tag, "_rx_data"}, 32'(bus_if.rx_data), 32'h00);
  endtask

  // monitor: pop and compare whenever the DUT presents a byte or an error
  always @(negedge clk) begin
    if (!rst && (bus_if.rx_valid || bus_if.rx_error)) begin
      chk("valid_error_exclusive", 32'(bus_if.rx_valid && bus_if.rx_error), 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: valid=%0b error=%0b data=%0h, none expected at %0t",
                 bus_if.rx_valid, bus_if.rx_error, bus_if.rx_data, $time);
      end else begin
        mon_ev = exp_q.pop_front();
        chk("event_is_error", 32'(bus_if.rx_error), 32'(mon_ev.is_err));
        if (!mon_ev.is_err) chk("rx_data", 32'(bus_if.rx_data), 32'(mon_ev.data));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.sample    = 1'b0;
    bus_if.nrzi_bit  = 1'b1;
    bus_if.stuffed   = 1'b0;
    bus_if.stuff_err = 1'b0;
    bus_if.se0       = 1'b0;
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // A5 after a full SYNC
    clear_pkt(); load_byte(8'hA5);
    do_sync(7); do_body(-1);

    // FF with a stuffed bit after six ones
    clear_pkt();
    for (int j = 0; j < 8; j++) add_bit(1'b1, (j == 5), 1'b0);
    do_sync(7); do_body(-1);

    // stuff error on bit 3
    clear_pkt(); load_byte(8'($urandom));
    do_sync(6); do_body(3);

    // 12 bits: one byte then a partial-byte error
    clear_pkt();
    for (int j = 0; j < 12; j++) add_bit(1'($urandom), 1'b0, 1'b0);
    do_sync(7); do_body(-1);

    // stuff error on the sample that would complete a byte
    clear_pkt(); load_byte(8'h0F); load_byte(8'hF0);
    do_sync(5); do_body(15);

    // too-short SYNC, then a valid one
    idle_ones(3);
    for (int k = 0; k < 4; k++) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
    chk("short_sync_shift_en", 32'(bus_if.shift_en), 32'd0);
    chk("short_sync_rx_active", 32'(bus_if.rx_active), 32'd0);
    clear_pkt(); load_byte(8'h5A);
    do_sync(6); do_body(-1);

    // reset mid-packet, then a fresh packet
    clear_pkt();
    do_sync(7);
    for (int k = 0; k < 5; k++) drive_bit(1'($urandom), 1'b0, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;
    #1 chk_all_zero("midpkt_reset");
    @(negedge clk) rst = 1'b0;
    clear_pkt(); load_byte(8'h3C);
    do_sync(7); do_body(-1);

    // randomized packets with stuffing, SE0 glitches and stuff errors
    for (int p = 0; p < 25; p++) begin
      int nb;
      int ep;
      clear_pkt();
      nb = $urandom_range(0, 40);
      for (int i = 0; i < nb; i++)
        add_bit(1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
      ep = (nb > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      do_sync($urandom_range(5, 9));
      do_body(ep);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
